// File: rtl/regfile_pipe.sv
// regfile_pipe: parametrised Y86-64 register file for the pipelined core.
//
// Two combinational read ports (srcA/srcB) and two clocked write ports (destE/destM).
// When destE == destM, the M port wins. An optional bypass forwards same-cycle write data
// to the read ports. A per-register scoreboard tracks pending writes for decode hazard
// detection.
//
// Ports:
//   CLK, RST_N           clock (rising edge), asynchronous active-low reset
//   srcA, srcB           read indices          -> valA, valB read data
//   destE/valE           E write port (ALU result)
//   destM/valM           M write port (memory result), has priority over E
//   issue_valid          decode issues an instruction this cycle
//   issue_destE/M        destinations being issued (set their busy bits)
//   busyA, busyB, stall  pending-write status of srcA/srcB, and their OR
// Any index >= NREG, including NONREG, means "no register".
module regfile_pipe #(
  parameter int unsigned         DATA_WID = 64,
  parameter int unsigned         ADDR_WID = 4,
  parameter int unsigned         NREG     = 15,
  parameter logic [ADDR_WID-1:0] NONREG   = '1,
  parameter bit                  BYPASS   = 1'b1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [ADDR_WID-1:0] srcA,
  input  logic [ADDR_WID-1:0] srcB,
  output logic [DATA_WID-1:0] valA,
  output logic [DATA_WID-1:0] valB,
  input  logic [ADDR_WID-1:0] destE,
  input  logic [DATA_WID-1:0] valE,
  input  logic [ADDR_WID-1:0] destM,
  input  logic [DATA_WID-1:0] valM,
  input  logic                issue_valid,
  input  logic [ADDR_WID-1:0] issue_destE,
  input  logic [ADDR_WID-1:0] issue_destM,
  output logic                busyA,
  output logic                busyB,
  output logic                stall
);

  localparam logic [ADDR_WID:0] NregW = (ADDR_WID + 1)'(NREG);

  logic [DATA_WID-1:0] r_regs [NREG];
  logic [NREG-1:0]     r_busy;
  logic [NREG-1:0]     w_busy_d;

  logic w_e_vld, w_m_vld, w_a_vld, w_b_vld, w_ie_vld, w_im_vld;

  assign w_e_vld  = ({1'b0, destE} < NregW) && (destE != NONREG);
  assign w_m_vld  = ({1'b0, destM} < NregW) && (destM != NONREG);
  assign w_a_vld  = ({1'b0, srcA} < NregW) && (srcA != NONREG);
  assign w_b_vld  = ({1'b0, srcB} < NregW) && (srcB != NONREG);
  assign w_ie_vld = issue_valid && ({1'b0, issue_destE} < NregW) && (issue_destE != NONREG);
  assign w_im_vld = issue_valid && ({1'b0, issue_destM} < NregW) && (issue_destM != NONREG);

  // Writeback clears, issue sets; a set in the same cycle wins (it is a new producer).
  always_comb begin
    w_busy_d = r_busy;
    for (int i = 0; i < NREG; i++) begin
      if ((w_e_vld && destE == ADDR_WID'(i)) || (w_m_vld && destM == ADDR_WID'(i))) begin
        w_busy_d[i] = 1'b0;
      end
      if ((w_ie_vld && issue_destE == ADDR_WID'(i)) ||
          (w_im_vld && issue_destM == ADDR_WID'(i))) begin
        w_busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        // M overrides E on a shared destination (popq %rsp).
        if (w_m_vld && destM == ADDR_WID'(i)) begin
          r_regs[i] <= valM;
        end else if (w_e_vld && destE == ADDR_WID'(i)) begin
          r_regs[i] <= valE;
        end
      end
      r_busy <= w_busy_d;
    end
  end

  always_comb begin
    valA  = '0;
    valB  = '0;
    busyA = 1'b0;
    busyB = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (srcA == ADDR_WID'(i)) begin
        valA  = r_regs[i];
        busyA = r_busy[i];
      end
      if (srcB == ADDR_WID'(i)) begin
        valB  = r_regs[i];
        busyB = r_busy[i];
      end
    end
    if (BYPASS) begin
      // A writeback landing this cycle both supplies the data and retires the hazard.
      if (w_a_vld && w_m_vld && srcA == destM) begin
        valA  = valM;
        busyA = 1'b0;
      end else if (w_a_vld && w_e_vld && srcA == destE) begin
        valA  = valE;
        busyA = 1'b0;
      end
      if (w_b_vld && w_m_vld && srcB == destM) begin
        valB  = valM;
        busyB = 1'b0;
      end else if (w_b_vld && w_e_vld && srcB == destE) begin
        valB  = valE;
        busyB = 1'b0;
      end
    end
    stall = busyA | busyB;
  end

endmodule

// File: tb/tb_regfile_pipe.sv
module tb_regfile_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  src_a, src_b, dest_e, dest_m, iss_e, iss_m;
  logic [63:0] val_e, val_m;
  logic        iss_v;

  logic [63:0] va1, vb1, va0, vb0;
  logic        ba1, bb1, st1, ba0, bb0, st0;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: 16 slots, slot 15 (NONREG) never written.
  logic [63:0] m_regs [16];
  bit          m_busy [16];

  always #5 clk = ~clk;

  regfile_pipe #(.BYPASS(1'b1)) u_dut_byp (
    .CLK(clk), .RST_N(rst_n), .srcA(src_a), .srcB(src_b), .valA(va1), .valB(vb1),
    .destE(dest_e), .valE(val_e), .destM(dest_m), .valM(val_m), .issue_valid(iss_v),
    .issue_destE(iss_e), .issue_destM(iss_m), .busyA(ba1), .busyB(bb1), .stall(st1)
  );

  regfile_pipe #(.BYPASS(1'b0)) u_dut_nob (
    .CLK(clk), .RST_N(rst_n), .srcA(src_a), .srcB(src_b), .valA(va0), .valB(vb0),
    .destE(dest_e), .valE(val_e), .destM(dest_m), .valM(val_m), .issue_valid(iss_v),
    .issue_destE(iss_e), .issue_destM(iss_m), .busyA(ba0), .busyB(bb0), .stall(st0)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_reg(input logic [3:0] idx);
    return (idx < 4'd15) && (idx != 4'hF);
  endfunction

  function automatic logic [63:0] exp_val(input logic [3:0] src, input bit byp);
    if (!is_reg(src)) return 64'd0;
    if (byp && is_reg(dest_m) && src == dest_m) return val_m;
    if (byp && is_reg(dest_e) && src == dest_e) return val_e;
    return m_regs[src];
  endfunction

  function automatic bit exp_busy(input logic [3:0] src, input bit byp);
    if (!is_reg(src)) return 1'b0;
    if (byp && ((is_reg(dest_m) && src == dest_m) || (is_reg(dest_e) && src == dest_e)))
      return 1'b0;
    return m_busy[src];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Effect of one rising edge with the current inputs.
  task automatic model_edge();
    if (is_reg(dest_e)) m_regs[dest_e] = val_e;
    if (is_reg(dest_m)) m_regs[dest_m] = val_m;
    if (is_reg(dest_e)) m_busy[dest_e] = 1'b0;
    if (is_reg(dest_m)) m_busy[dest_m] = 1'b0;
    if (iss_v && is_reg(iss_e)) m_busy[iss_e] = 1'b1;
    if (iss_v && is_reg(iss_m)) m_busy[iss_m] = 1'b1;
  endtask

  // Called just after a falling edge with inputs already set: compare, then step the model.
  task automatic cycle();
    bit eb;
    #2;
    if (!rst_n) model_clear();
    check_val("valA_byp", va1, exp_val(src_a, 1'b1));
    check_val("valB_byp", vb1, exp_val(src_b, 1'b1));
    check_val("valA_nob", va0, exp_val(src_a, 1'b0));
    check_val("valB_nob", vb0, exp_val(src_b, 1'b0));
    check_val("busyA_byp", 64'(ba1), 64'(exp_busy(src_a, 1'b1)));
    check_val("busyB_byp", 64'(bb1), 64'(exp_busy(src_b, 1'b1)));
    check_val("busyA_nob", 64'(ba0), 64'(exp_busy(src_a, 1'b0)));
    check_val("busyB_nob", 64'(bb0), 64'(exp_busy(src_b, 1'b0)));
    eb = exp_busy(src_a, 1'b1) | exp_busy(src_b, 1'b1);
    check_val("stall_byp", 64'(st1), 64'(eb));
    eb = exp_busy(src_a, 1'b0) | exp_busy(src_b, 1'b0);
    check_val("stall_nob", 64'(st0), 64'(eb));
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    dest_e = 4'hF; dest_m = 4'hF; iss_v = 1'b0; iss_e = 4'hF; iss_m = 4'hF;
    val_e = '0; val_m = '0;
  endtask

  function automatic logic [3:0] pick();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 7) return 4'hF;
    if (r == 6) return 4'd14;
    return 4'(r);
  endfunction

  initial begin
    model_clear();
    rst_n = 1'b0;
    src_a = 4'd0; src_b = 4'd1;
    idle_inputs();
    // Writes during reset must be ignored.
    dest_e = 4'd0; val_e = 64'd3;
    @(negedge clk);
    repeat (3) cycle();

    rst_n = 1'b1; idle_inputs();
    #1;
    check_val("rst_valA", va0, 64'd0);
    check_val("rst_stall", 64'(st1), 64'd0);
    cycle();

    // irmovq $3,%rax ; rrmovq %rax,%rcx
    dest_e = 4'd0; val_e = 64'd3;
    cycle();
    src_a = 4'd0; dest_e = 4'd1; val_e = 64'd3; src_b = 4'd1;
    #1;
    check_val("irmov_valA", va0, 64'd3);
    cycle();
    idle_inputs();
    #1;
    check_val("rrmov_valB", vb0, 64'd3);
    cycle();

    // Bypass vs. stored
    dest_e = 4'd2; val_e = 64'd7; src_a = 4'd2;
    #1;
    check_val("byp_same", va1, 64'd7);
    check_val("nob_old", va0, 64'd0);
    cycle();
    idle_inputs();
    #1;
    check_val("nob_after", va0, 64'd7);
    cycle();

    // M-over-E priority
    dest_e = 4'd4; val_e = 64'd56; dest_m = 4'd4; val_m = 64'd21; src_b = 4'd4;
    #1;
    check_val("prio_byp", vb1, 64'd21);
    cycle();
    idle_inputs();
    #1;
    check_val("prio_reg", vb0, 64'd21);
    cycle();

    // NONREG
    dest_e = 4'hF; val_e = 64'd99; src_a = 4'hF; iss_v = 1'b1; iss_m = 4'hF;
    #1;
    check_val("nonreg_val", va1, 64'd0);
    check_val("nonreg_busy", 64'(ba1), 64'd0);
    cycle();
    idle_inputs();
    cycle();

    // Scoreboard
    iss_v = 1'b1; iss_m = 4'd6;
    cycle();
    idle_inputs(); src_a = 4'd6;
    #1;
    check_val("sb_busy", 64'(ba0), 64'd1);
    check_val("sb_stall", 64'(st1), 64'd1);
    cycle();
    dest_m = 4'd6; val_m = 64'd19;
    #1;
    check_val("sb_mask", 64'(ba1), 64'd0);
    check_val("sb_nomask", 64'(ba0), 64'd1);
    cycle();
    idle_inputs();
    #1;
    check_val("sb_clear", 64'(ba0), 64'd0);
    cycle();
    iss_v = 1'b1; iss_m = 4'd6; dest_m = 4'd6; val_m = 64'd5;
    cycle();
    idle_inputs();
    #1;
    check_val("sb_setwin", 64'(ba0), 64'd1);
    check_val("sb_setwin_b", 64'(ba1), 64'd1);
    cycle();

    // Asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    check_val("arst_busy", 64'(ba0), 64'd0);
    check_val("arst_val", vb0, 64'd0);
    cycle();
    rst_n = 1'b1;
    cycle();

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      rst_n  = ($urandom_range(0, 49) != 0);
      src_a  = pick(); src_b = pick();
      dest_e = pick(); dest_m = pick();
      val_e  = {$urandom, $urandom};
      val_m  = {$urandom, $urandom};
      iss_v  = $urandom_range(0, 1) == 1;
      iss_e  = pick(); iss_m = pick();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
